// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - JK bank excitation sequencer with settle, verify and bounded retry
module jk_excitation_driver #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] Q_fb,
    input  logic [WIDTH-1:0] Qb_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             jk_en,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [1:0]       retries
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        STROBE = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] target, target_n;
    logic [1:0]       retry_cnt, retry_n;
    logic [SW-1:0]    settle_cnt, settle_n;
    logic [WIDTH-1:0] j_n, k_n;
    logic             jk_en_n, done_n, error_n;
    logic [1:0]       code_n, retries_n;
    logic             complement_fault;

    assign tgt_ready        = (state == IDLE);
    assign complement_fault = |(~(Q_fb ^ Qb_fb));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target     <= '0;
            retry_cnt  <= '0;
            settle_cnt <= '0;
            J          <= '0;
            K          <= '0;
            jk_en      <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
            retries    <= 2'b00;
        end else begin
            state      <= state_n;
            target     <= target_n;
            retry_cnt  <= retry_n;
            settle_cnt <= settle_n;
            J          <= j_n;
            K          <= k_n;
            jk_en      <= jk_en_n;
            done       <= done_n;
            error      <= error_n;
            err_code   <= code_n;
            retries    <= retries_n;
        end
    end

    always_comb begin
        state_n   = state;
        target_n  = target;
        retry_n   = retry_cnt;
        settle_n  = settle_cnt;
        j_n       = '0;
        k_n       = '0;
        jk_en_n   = 1'b0;
        done_n    = 1'b0;
        error_n   = 1'b0;
        code_n    = err_code;
        retries_n = retries;
        case (state)
            IDLE: begin
                if (tgt_valid && tgt_ready) begin
                    target_n  = tgt_data;
                    retry_n   = 2'd0;
                    code_n    = 2'b00;
                    retries_n = 2'd0;
                    state_n   = DRIVE;
                end
            end
            DRIVE: begin
                // Only set or reset codes; unchanged bits hold, toggle is never used.
                j_n     = ~Q_fb & target;
                k_n     = Q_fb & ~target;
                jk_en_n = 1'b1;
                state_n = STROBE;
            end
            STROBE: begin
                settle_n = SW'(SETTLE_CYCLES);
                state_n  = SETTLE;
            end
            SETTLE: begin
                settle_n = settle_cnt - 1'b1;
                if (settle_cnt == SW'(1))
                    state_n = CHECK;
            end
            CHECK: begin
                state_n = IDLE;
                if (complement_fault) begin
                    error_n = 1'b1;
                    code_n  = 2'b10;
                end else if (Q_fb == target) begin
                    done_n = 1'b1;
                    code_n = 2'b00;
                end else if (retry_cnt < 2'(MAX_RETRY)) begin
                    retry_n = retry_cnt + 2'd1;
                    state_n = DRIVE;
                end else begin
                    error_n = 1'b1;
                    code_n  = 2'b01;
                end
                retries_n = retry_n;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
